// File: rtl/alu_decode_stage_if.sv
// Decode-stage bus: fetch-side handshake, flush, and the decoded ALU entry.
// The ALU select codes live here so the stage and its consumers share one table.
`ifndef ALU_DECODE_CODES
`define ALU_DECODE_CODES
`define ALU_ADD   5'd0
`define ALU_SUB   5'd1
`define ALU_SLL   5'd2
`define ALU_SLT   5'd3
`define ALU_SLTU  5'd4
`define ALU_XOR   5'd5
`define ALU_SRL   5'd6
`define ALU_SRA   5'd7
`define ALU_OR    5'd8
`define ALU_AND   5'd9
`define ALU_ADDI  5'd10
`define ALU_SLTIU 5'd11
`define ALU_ORI   5'd12
`define ALU_ANDI  5'd13
`define ALU_SLLI  5'd14
`define ALU_SRLI  5'd15
`define ALU_SRAI  5'd16
`endif

interface alu_decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      alu_select;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic            reg_write;
  logic            illegal;

  // Upstream/downstream agent that drives words in and accepts entries.
  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_select, rs1, rs2, rd, imm, use_imm, reg_write, illegal
  );

  // The decode stage itself.
  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_select, rs1, rs2, rd, imm, use_imm, reg_write, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage for OP / OP-IMM / LUI. Output register plus one skid
// register give a 2-deep FIFO with a registered in_ready and 1-cycle latency.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  alu_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [4:0]      alu_select;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ok;
  dec_t       w_dec;

  dec_t r_out, r_skid;
  logic r_out_vld, r_skid_vld, r_in_ready;

  dec_t w_out_nxt, w_skid_nxt;
  logic w_out_vld_nxt, w_skid_vld_nxt;
  logic w_acc, w_free;

  assign w_opc = bus.in_instr[6:0];
  assign w_f3  = bus.in_instr[14:12];
  assign w_f7  = bus.in_instr[31:25];

  // Combinational decode of the offered word; anything unrecognised collapses
  // to a harmless ADD with illegal=1 so it still flows in order.
  always_comb begin
    w_dec            = '0;
    w_dec.rd         = bus.in_instr[11:7];
    w_dec.rs1        = bus.in_instr[19:15];
    w_dec.rs2        = bus.in_instr[24:20];
    w_dec.alu_select = `ALU_ADD;
    w_ok             = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_dec.reg_write = 1'b1;
        case (w_f3)
          3'b000: begin
            if (w_f7 == F7_ZERO)     begin w_ok = 1'b1; w_dec.alu_select = `ALU_ADD; end
            else if (w_f7 == F7_ALT) begin w_ok = 1'b1; w_dec.alu_select = `ALU_SUB; end
          end
          3'b101: begin
            if (w_f7 == F7_ZERO)     begin w_ok = 1'b1; w_dec.alu_select = `ALU_SRL; end
            else if (w_f7 == F7_ALT) begin w_ok = 1'b1; w_dec.alu_select = `ALU_SRA; end
          end
          3'b001:  begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_SLL;  end
          3'b010:  begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_SLT;  end
          3'b011:  begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_SLTU; end
          3'b100:  begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_XOR;  end
          3'b110:  begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_OR;   end
          default: begin w_ok = (w_f7 == F7_ZERO); w_dec.alu_select = `ALU_AND;  end
        endcase
      end
      OPC_OP_IMM: begin
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.rs2       = 5'd0;
        w_dec.imm       = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        w_ok            = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_select = `ALU_ADDI;
          3'b010: w_dec.alu_select = `ALU_SLT;   // SLTI keeps the signed compare
          3'b011: w_dec.alu_select = `ALU_SLTIU;
          3'b100: w_dec.alu_select = `ALU_XOR;
          3'b110: w_dec.alu_select = `ALU_ORI;
          3'b111: w_dec.alu_select = `ALU_ANDI;
          3'b001: begin
            w_dec.imm        = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            w_dec.alu_select = `ALU_SLLI;
            w_ok             = (w_f7 == F7_ZERO);
          end
          default: begin
            w_dec.imm        = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            w_dec.alu_select = (w_f7 == F7_ALT) ? `ALU_SRAI : `ALU_SRLI;
            w_ok             = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        w_ok            = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
        w_dec.rs1       = 5'd0;
        w_dec.rs2       = 5'd0;
        w_dec.imm       = {bus.in_instr[31:12], 12'b0};
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) begin
      w_dec.alu_select = `ALU_ADD;
      w_dec.rs1        = bus.in_instr[19:15];
      w_dec.rs2        = bus.in_instr[24:20];
      w_dec.imm        = '0;
      w_dec.use_imm    = 1'b0;
      w_dec.reg_write  = 1'b0;
      w_dec.illegal    = 1'b1;
    end
  end

  assign w_acc  = bus.in_valid & r_in_ready;
  assign w_free = ~r_out_vld | bus.out_ready;

  // Next state of the output/skid pair: skid always refills the output first,
  // a stalled output diverts a new word to the skid, flush wins over all.
  always_comb begin
    w_out_nxt      = r_out;
    w_out_vld_nxt  = r_out_vld;
    w_skid_nxt     = r_skid;
    w_skid_vld_nxt = r_skid_vld;
    if (bus.flush) begin
      w_out_vld_nxt  = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (w_free) begin
      if (r_skid_vld) begin
        w_out_nxt      = r_skid;
        w_out_vld_nxt  = 1'b1;
        w_skid_vld_nxt = w_acc;
        if (w_acc) w_skid_nxt = w_dec;
      end else begin
        w_out_vld_nxt = w_acc;
        if (w_acc) w_out_nxt = w_dec;
      end
    end else if (w_acc) begin
      w_skid_nxt     = w_dec;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // State registers; in_ready is registered as the inverse of next skid valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_out      <= w_out_nxt;
      r_skid     <= w_skid_nxt;
      r_out_vld  <= w_out_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_in_ready <= ~w_skid_vld_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_vld;
  assign bus.alu_select = r_out.alu_select;
  assign bus.rs1        = r_out.rs1;
  assign bus.rs2        = r_out.rs2;
  assign bus.rd         = r_out.rd;
  assign bus.imm        = r_out.imm;
  assign bus.use_imm    = r_out.use_imm;
  assign bus.reg_write  = r_out.reg_write;
  assign bus.illegal    = r_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed words, backpressure/flush/reset, then
// random traffic against a 2-deep FIFO model fed by an instruction-level decoder.
module tb_alu_decode_stage;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,
                         SLTU = 5'd4, XORC = 5'd5, SRL = 5'd6,  SRA = 5'd7,
                         ORC = 5'd8,  ANDC = 5'd9, ADDI = 5'd10, SLTIU = 5'd11,
                         ORI = 5'd12, ANDI = 5'd13, SLLI = 5'd14, SRLI = 5'd15,
                         SRAI = 5'd16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_decode_stage_if #(.XLEN(32)) bus();
  alu_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    logic [4:0]  alu, rs1, rs2, rd;
    logic [31:0] imm;
    bit          use_imm, wr, ill;
  } exp_t;

  exp_t q[$];

  // Instruction-level reference: funct3 indexes the mnemonic tables directly.
  logic [4:0] r_tbl [0:7] = '{ADD, SLL, SLT, SLTU, XORC, SRL, ORC, ANDC};
  logic [4:0] i_tbl [0:7] = '{ADDI, SLLI, SLT, SLTIU, XORC, SRLI, ORI, ANDI};

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.imm = 32'd0; e.use_imm = 0; e.wr = 1; e.ill = 0; e.alu = ADD;
    if (op == 7'h33) begin
      if (f7 == 7'h00)                   e.alu = r_tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu = SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu = SRA;
      else                               e.ill = 1;
    end else if (op == 7'h13) begin
      e.use_imm = 1; e.rs2 = 5'd0;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = 32'(w[24:20]);
        if (f7 == 7'h00)                    e.alu = i_tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = SRAI;
        else                                e.ill = 1;
      end else begin
        e.imm = 32'($signed(w[31:20]));
        e.alu = i_tbl[f3];
      end
    end else if (op == 7'h37) begin
      e.rs1 = 5'd0; e.rs2 = 5'd0; e.use_imm = 1; e.imm = {w[31:12], 12'h000};
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin e.wr = 0; e.alu = ADD; e.imm = 32'd0; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3 = 3'($urandom);
    logic [6:0] f7;
    logic [4:0] a = 5'($urandom), b = 5'($urandom), c = 5'($urandom);
    case ($urandom_range(0, 4))
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, b, a, f3, c, 7'h33};
      end
      1: begin
        f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
        return {f7, b, a, f3, c, 7'h33};
      end
      2: begin
        case ($urandom_range(0, 2))
          0:       f7 = 7'h00;
          1:       f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        return {f7, b, a, f3, c, 7'h13};
      end
      3: return {20'($urandom), c, 7'h37};
      default: return $urandom;
    endcase
  endfunction

  task automatic check_state();
    exp_t h;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      h = q[0];
      chk("alu_select", 32'(bus.alu_select), 32'(h.alu));
      chk("illegal", 32'(bus.illegal), 32'(h.ill));
      chk("reg_write", 32'(bus.reg_write), 32'(h.wr));
      chk("imm", bus.imm, h.imm);
      if (!h.ill) begin
        chk("rs1", 32'(bus.rs1), 32'(h.rs1));
        chk("rs2", 32'(bus.rs2), 32'(h.rs2));
        chk("rd", 32'(bus.rd), 32'(h.rd));
        chk("use_imm", 32'(bus.use_imm), 32'(h.use_imm));
      end
    end
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance model.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    bit acc, drn;
    check_state();
    bus.in_valid = v; bus.in_instr = w; bus.out_ready = ordy; bus.flush = fl;
    if (fl) q.delete();
    else begin
      acc = v && (q.size() < 2);
      drn = ordy && (q.size() != 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(w));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] W1 = 32'h00100513;  // addi x10,x0,1
  localparam logic [31:0] W2 = 32'h00100593;  // addi x11,x0,1
  localparam logic [31:0] W3 = 32'h00100613;  // addi x12,x0,1

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.in_instr = 32'd0; bus.out_ready = 1; bus.flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst imm", bus.imm, 32'd0);
    chk("rst rd", 32'(bus.rd), 32'd0);
    chk("rst reg_write", 32'(bus.reg_write), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed words with the downstream always ready.
    step(1, 32'h002081B3, 1, 0);
    chk("add alu", 32'(bus.alu_select), 32'(ADD));
    chk("add rs1", 32'(bus.rs1), 32'd1);
    chk("add rs2", 32'(bus.rs2), 32'd2);
    chk("add rd", 32'(bus.rd), 32'd3);
    chk("add use_imm", 32'(bus.use_imm), 32'd0);
    chk("add reg_write", 32'(bus.reg_write), 32'd1);
    step(1, 32'hFFF00293, 1, 0);
    chk("addi alu", 32'(bus.alu_select), 32'(ADDI));
    chk("addi imm", bus.imm, 32'hFFFFFFFF);
    chk("addi rd", 32'(bus.rd), 32'd5);
    step(1, 32'h4033D313, 1, 0);
    chk("srai alu", 32'(bus.alu_select), 32'(SRAI));
    chk("srai imm", bus.imm, 32'd3);
    chk("srai rs1", 32'(bus.rs1), 32'd7);
    step(1, 32'h123450B7, 1, 0);
    chk("lui imm", bus.imm, 32'h12345000);
    chk("lui rs1", 32'(bus.rs1), 32'd0);
    step(1, 32'h0000006F, 1, 0);
    chk("jal illegal", 32'(bus.illegal), 32'd1);
    chk("jal reg_write", 32'(bus.reg_write), 32'd0);
    step(0, 32'd0, 1, 0);

    // Backpressure: three words offered, two held, outputs frozen.
    step(1, W1, 0, 0);
    step(1, W2, 0, 0);
    step(1, W3, 0, 0);
    chk("bp in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp head rd", 32'(bus.rd), 32'd10);
    step(1, W3, 0, 0);
    chk("bp stable rd", 32'(bus.rd), 32'd10);
    chk("bp stable imm", bus.imm, 32'd1);
    step(1, W3, 1, 0);
    chk("bp order 2", 32'(bus.rd), 32'd11);
    step(1, W3, 1, 0);
    chk("bp order 3", 32'(bus.rd), 32'd12);
    step(0, 32'd0, 1, 0);
    chk("bp drained", 32'(bus.out_valid), 32'd0);

    // Flush with both slots full and a word offered in the same cycle.
    step(1, W1, 0, 0);
    step(1, W2, 0, 0);
    step(1, W3, 1, 1);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    step(0, 32'd0, 1, 0);

    // Asynchronous reset in the middle of a stall.
    step(1, W1, 0, 0);
    step(1, W2, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst rd", 32'(bus.rd), 32'd0);
    q.delete();
    bus.in_valid = 0; bus.out_ready = 1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic against the FIFO model.
    repeat (600)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0);
    check_state();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
